// File: rtl/dct_adder_tree_p.sv
// dct_adder_tree_p: pipelined split-carry signed adder tree with scale, round, saturate; ports clk, rst, in_valid, n_flat in; out_valid, dct, ovf out
module dct_adder_tree_p #(
  parameter int NUM_IN = 8,
  parameter int IN_W = 14,
  parameter int LSB_W = 8,
  parameter int SHIFT = 5,
  parameter int OUT_W = 12,
  parameter int ROUND = 0,
  parameter int SAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic [NUM_IN*IN_W-1:0] n_flat,
  output logic out_valid,
  output logic [OUT_W-1:0] dct,
  output logic ovf
);
  localparam int LEVELS = $clog2(NUM_IN);
  localparam int SUM_W = IN_W + LEVELS;
  localparam int LATENCY = 2 * LEVELS + 1;
  localparam logic [SUM_W:0] RND = (ROUND != 0 && SHIFT > 0) ? (SUM_W+1)'(1) << (SHIFT > 0 ? SHIFT - 1 : 0) : '0;
  localparam logic signed [SUM_W:0] MAXV = (SUM_W+1)'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [SUM_W:0] MINV = ~MAXV;
  logic [LATENCY-1:0] vld;
  logic [SUM_W-1:0] s;
  logic signed [SUM_W:0] t, v;
  logic hi, lo;
  logic [OUT_W-1:0] dct_n;
  for (genvar k = 0; k < LEVELS; k++) begin : lv
    localparam int W = IN_W + k;
    localparam int N = NUM_IN >> (k + 1);
    localparam int H = W - LSB_W;
    logic [2*N*W-1:0] opd;
    logic [N*(LSB_W+1)-1:0] lo_a;
    logic [N*H-1:0] ha, hb;
    logic [N*LSB_W-1:0] lo_b;
    logic [N*(H+1)-1:0] hi_b;
    logic [N*(W+1)-1:0] res;
    if (k == 0) begin : src
      assign opd = n_flat;
    end else begin : src
      assign opd = lv[k-1].res;
    end
    for (genvar j = 0; j < N; j++) begin : pr
      // cycle A: low fields plus carry out; cycle B: sign-extended high fields absorb that carry
      always_ff @(posedge clk) begin
        if (rst) begin
          lo_a[j*(LSB_W+1) +: LSB_W+1] <= '0;
          ha[j*H +: H] <= '0;
          hb[j*H +: H] <= '0;
          lo_b[j*LSB_W +: LSB_W] <= '0;
          hi_b[j*(H+1) +: H+1] <= '0;
        end else begin
          lo_a[j*(LSB_W+1) +: LSB_W+1] <= {1'b0, opd[2*j*W +: LSB_W]} + {1'b0, opd[(2*j+1)*W +: LSB_W]};
          ha[j*H +: H] <= opd[2*j*W+LSB_W +: H];
          hb[j*H +: H] <= opd[(2*j+1)*W+LSB_W +: H];
          lo_b[j*LSB_W +: LSB_W] <= lo_a[j*(LSB_W+1) +: LSB_W];
          hi_b[j*(H+1) +: H+1] <= {ha[j*H+H-1], ha[j*H +: H]} + {hb[j*H+H-1], hb[j*H +: H]}
            + {{H{1'b0}}, lo_a[j*(LSB_W+1)+LSB_W]};
        end
      end
      assign res[j*(W+1) +: W+1] = {hi_b[j*(H+1) +: H+1], lo_b[j*LSB_W +: LSB_W]};
    end
  end
  assign s = lv[LEVELS-1].res;
  always_comb begin
    t = $signed({s[SUM_W-1], s}) + $signed(RND);
    v = t >>> SHIFT;
    hi = v > MAXV;
    lo = v < MINV;
    dct_n = (SAT != 0 && hi) ? MAXV[OUT_W-1:0] : (SAT != 0 && lo) ? MINV[OUT_W-1:0] : v[OUT_W-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      dct <= '0;
      ovf <= 1'b0;
    end else begin
      vld <= {vld[LATENCY-2:0], in_valid};
      dct <= dct_n;
      ovf <= hi | lo;
    end
  end
  assign out_valid = vld[LATENCY-1];
endmodule

// File: doc/dct_adder_tree_p.md
Name: dct_adder_tree_p

Overview:
- Parametrised, fully pipelined signed adder tree. Sums NUM_IN two's-complement inputs, then scales the result by a right shift, with selectable rounding and saturation.
- Sits at the output of the DCT multiply array. It replaces the fixed eight-input, 14-bit tree in that position.
- Each tree level uses a split-carry pipeline: low field added in one cycle, high field plus carry in the next. This keeps the adder critical path at LSB_W bits.
- New versus the fixed tree: synchronous reset, valid tracking, round-half-up mode, saturation, overflow flag, and configurable width and depth.

Parameters:
- NUM_IN, 8, number of operands; power of 2, 2..32. LEVELS = log2(NUM_IN).
- IN_W, 14, width of each signed operand.
- LSB_W, 8, width of the low field added in the first cycle of each level; 1 <= LSB_W < IN_W.
- SHIFT, 5, right-shift (scale) applied to the full sum; 0 <= SHIFT < SUM_W, where SUM_W = IN_W + LEVELS.
- OUT_W, 12, width of the signed output; OUT_W <= SUM_W - SHIFT + 1.
- ROUND, 0, 0 = truncate (floor, arithmetic shift); 1 = round half up (add 2^(SHIFT-1) before the shift; ignored when SHIFT = 0).
- SAT, 1, 1 = clamp to the OUT_W signed range; 0 = wrap (keep the low OUT_W bits).

Ports:
- clk  in  1  clock; all registers update on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  qualifies n_flat on this cycle.
- n_flat  in  NUM_IN*IN_W  packed operands; operand i occupies bits [i*IN_W +: IN_W].
- out_valid  out  1  dct and ovf are valid this cycle.
- dct  out  OUT_W  scaled, rounded, saturated sum (signed).
- ovf  out  1  the scaled value did not fit in OUT_W (clamped if SAT=1, wrapped if SAT=0).

Behaviour:
- Reset:
  - Clock is clk; reset is rst, synchronous and active-high.
  - While rst is high at a clock edge, every pipeline register, including the valid shift chain, is cleared to 0.
  - One cycle after reset: out_valid=0, dct=0, ovf=0.
  - Reset asserted mid-stream discards all in-flight samples; no out_valid pulse for them ever appears.
- Pipeline:
  - Free-running, no backpressure; accepts one sample per cycle.
  - LATENCY = 2*LEVELS + 1 clocks (7 at defaults).
  - A sample presented with in_valid=1 before edge 0 appears on dct/ovf with out_valid=1 after edge LATENCY-1.
  - in_valid is a sideband signal delayed LATENCY cycles. Data registers update regardless of valid. Only out_valid is gated.
- Level k (0-based) operands are IN_W+k bits wide.
  - Cycle A: add the low LSB_W bits of each pair to get an (LSB_W+1)-bit result. Register it and the operands' high fields.
  - Cycle B: add the sign-extended high fields plus the registered carry (bit LSB_W). The result high field is IN_W+k+1-LSB_W bits. The low LSB_W bits are delayed alongside it.
  - Level k+1 consumes {high, low} as (IN_W+k+1)-bit operands.
  - The final level yields the full sum S of SUM_W bits. S is exact; it never overflows.
- Output stage (final register):
  - T = S + (ROUND ? 2^(SHIFT-1) : 0), computed at SUM_W+1 bits.
  - V = T >>> SHIFT (arithmetic shift).
  - If V is within [-2^(OUT_W-1), 2^(OUT_W-1)-1]: dct = V and ovf = 0.
  - Otherwise ovf = 1, and dct is the clamp limit (SAT=1) or V[OUT_W-1:0] (SAT=0).
- Back-to-back valid samples never interact. Each sample's result depends only on its own operands.
- No internal state machine beyond the pipeline. Results depend only on input history within the last LATENCY cycles.

Test Plan:
All scenarios use default parameters unless stated; results are checked at LATENCY=7.
1. Reset then idle: hold rst=1 for 3 cycles with random n_flat and in_valid=1, then release with in_valid=0 -> out_valid stays 0, dct=0 and ovf=0 throughout, and for the 7 cycles after release.
2. Scaling and carry: all operands 32 -> dct=8 (0x008), ovf=0. Then n0=255, n1=1, others 0 (carry out of the low field) -> dct=8, out_valid=1 exactly 7 cycles after each in_valid.
3. Negative rounding: all operands -1, ROUND=0 -> dct=0xFFF (-1). Rebuild with ROUND=1 -> dct=0, ovf=0.
4. Extremes:
   - All operands 8191, ROUND=0 -> dct=2047, ovf=0.
   - Same inputs, ROUND=1 -> dct=2047, ovf=1.
   - Same inputs, ROUND=1, SAT=0 -> dct=0x800, ovf=1.
   - All operands -8192 -> dct=-2048 (0x800), ovf=0.
5. Streaming and reset: 20 consecutive valid random samples with one in_valid=0 gap -> out_valid shows the identical pattern 7 cycles later and every dct matches the reference model. Repeat with rst pulsed for one cycle mid-stream -> samples in flight at the reset edge never produce out_valid; samples accepted afterwards complete normally.
6. Re-parametrised build, NUM_IN=4, IN_W=10, LSB_W=4, SHIFT=0, OUT_W=12 -> LATENCY=5. Inputs {511, 511, -512, 1} -> dct=511. Random regression against the reference model.
